rxuart_autobaud: RTL and testbench
==================================

Name: rxuart_autobaud

Overview:
- Automatic baud-rate controller for the rxuart receiver.
- When armed, it measures the bit period of a 0x55 sync character arriving on the synchronized rx line, then computes the receiver's 31-bit setup word.
- It pulses the receiver's reset so the receiver reloads the new setup in its reset-idle state.
- Sits between the bus register file (arm, format bits) and rxuart's i_setup/i_reset inputs.

Parameters:
- INITIAL_SETUP, 31'd868: o_setup value at reset.
- TIMEOUT, 28'hFFF_FFFF: max cycles allowed in MEASURE before failing.
- MIN_BAUD, 24'd4: smallest accepted clocks-per-baud result.
- GUARD, 16'd32: consecutive high cycles required before the start edge is accepted.
- SYNC_CHAR, 8'h55: character expected in the verify phase.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous active-high reset
- i_ck_uart  in  1  synchronized rx line (rxuart o_ck_uart)
- i_arm  in  1  one-cycle pulse: start autobaud
- i_abort  in  1  one-cycle pulse: cancel, return to IDLE
- i_format  in  6  setup bits [29:24] (data bits, stop, parity ctl)
- i_rx_wr  in  1  rxuart o_wr
- i_rx_data  in  8  rxuart o_data
- o_setup  out  31  setup word to rxuart i_setup
- o_rx_reset  out  1  reset request ORed into rxuart i_reset
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse: new setup applied successfully
- o_fail  out  1  one-cycle pulse: timeout, range error, abort or verify mismatch

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_reset is asynchronous and active-high.
- Reset values:
  - State = IDLE.
  - o_setup = INITIAL_SETUP.
  - o_rx_reset = 0, o_busy = 0, o_done = 0, o_fail = 0.
  - Counters = 0; prev_rx = 1.
- Falling edge detection: fall = prev_rx & ~i_ck_uart, with prev_rx registered every cycle.
- States and transitions:
  - IDLE: on i_arm go to GUARD_WAIT with guard_cnt = 0. If i_arm and i_abort arrive in the same cycle, abort wins: stay in IDLE with no o_fail.
  - GUARD_WAIT: guard_cnt increments while i_ck_uart = 1 and clears when it is 0. When guard_cnt == GUARD-1 with the line high, go to WAIT_START.
  - WAIT_START: on fall, set cnt = 0 and edges = 0, then go to MEASURE. No timeout in this state.
  - MEASURE:
    - cnt increments every cycle, saturating at TIMEOUT.
    - On each fall, edges increments.
    - On the 4th fall after the start edge (8 bit times for 0x55), capture N = cnt + 1 and go to CALC.
    - If cnt == TIMEOUT, go to FAIL.
  - CALC (1 cycle):
    - baud = (N + 4) >> 3, rounded to nearest, 28-bit arithmetic.
    - If baud < MIN_BAUD or baud > 24'hFF_FFFF, go to FAIL.
    - Otherwise set o_setup = {1'b0, i_format, baud[23:0]} and go to APPLY.
  - APPLY: o_rx_reset = 1 for exactly 2 cycles, then go to VERIFY if the verify feature is compiled in, else to DONE.
  - DONE: o_done = 1 for one cycle, then go to IDLE.
  - FAIL: o_fail = 1 for one cycle, then go to IDLE. o_setup is left unchanged by a failure.
- i_abort in any non-IDLE state: go to FAIL next cycle. If the abort occurs during APPLY, o_rx_reset still completes its 2 cycles before FAIL.
- i_arm while o_busy is high: ignored.
- Reset mid-operation: immediate return to reset values; o_setup reverts to INITIAL_SETUP.
- Latency from the 4th measured fall to o_done: 4 cycles (CALC 1, APPLY 2, DONE 1), without the verify feature.

Optional Feature:
- Macro: RXUART_AUTOBAUD_VERIFY_EN.
- Defined: adds a VERIFY state after APPLY.
  - Waits for i_rx_wr. If i_rx_data == SYNC_CHAR, go to DONE; otherwise go to FAIL with o_setup restored to its pre-arm value (the state saves it).
  - If no i_rx_wr arrives within 16×baud cycles, go to FAIL.
- Undefined: no VERIFY state and no saved-setup register; i_rx_wr and i_rx_data are unused.

Decomposition:
- Package rxuart_pkg holds:
  - The state enum (IDLE, GUARD_WAIT, WAIT_START, MEASURE, CALC, APPLY, VERIFY, DONE, FAIL).
  - Setup field positions: BAUD 23:0, FORMAT 29:24.
  - Default SYNC_CHAR.
- Sub-module: rxuart_edge_timer, containing prev_rx, fall detection, the cycle counter and the edge counter. Inputs: clear and enable; outputs: fall, edges, cnt, sat.
- The FSM stays in rxuart_autobaud.

Test Plan:
- Reset 0x3000364, arm, 50 idle-high cycles, then 0x55 at 868 clk/bit -> o_setup[23:0]=868, [29:24]=i_format, o_rx_reset high 2 cycles, o_done 4 cycles after 4th fall.
- 0x55 at 217 clk/bit with ±3-cycle edge jitter -> baud=217 (rounding); at 869.5 avg (N=6956) -> 870.
- Arm, single falling edge then line held low, TIMEOUT=1000 -> o_fail at cycle ~1001 of MEASURE; o_setup unchanged.
- 0x55 at 2 clk/bit, MIN_BAUD=4 -> o_fail, no o_rx_reset.
- i_reset asserted mid-MEASURE -> outputs to reset values asynchronously; later arm measures normally; i_abort mid-GUARD_WAIT -> o_fail next cycle.
- With RXUART_AUTOBAUD_VERIFY_EN: i_rx_wr with data 8'h41 -> o_fail and o_setup restored; data 8'h55 -> o_done.

Source files
------------

// File: rtl/rxuart_pkg.sv
`default_nettype none
//----------------------------------------------------------------------------
//  Module     : rxuart_pkg
//  Description: Shared definitions for the rxuart auto-baud controller:
//               FSM state encodings, setup-word field positions, the
//               counter width, the default sync character and the
//               clocks-per-baud rounding helper.
//  Revision   : 1.0 - initial release
//----------------------------------------------------------------------------
package rxuart_pkg;

    // Auto-baud FSM state encoding
    typedef logic [3:0] state_t;

    localparam state_t c_ST_IDLE       = 4'd0;
    localparam state_t c_ST_GUARD_WAIT = 4'd1;
    localparam state_t c_ST_WAIT_START = 4'd2;
    localparam state_t c_ST_MEASURE    = 4'd3;
    localparam state_t c_ST_CALC       = 4'd4;
    localparam state_t c_ST_APPLY      = 4'd5;
    localparam state_t c_ST_VERIFY     = 4'd6;
    localparam state_t c_ST_DONE       = 4'd7;
    localparam state_t c_ST_FAIL       = 4'd8;

    // Field positions inside the 31-bit rxuart setup word
    localparam int c_BAUD_LSB   = 0;
    localparam int c_BAUD_MSB   = 23;
    localparam int c_FORMAT_LSB = 24;
    localparam int c_FORMAT_MSB = 29;

    // Width of the bit-period counter
    localparam int c_CNT_W = 28;

    // Character the verify phase expects (0x55 gives four falling edges)
    localparam logic [7:0] c_SYNC_CHAR_DEFAULT = 8'h55;

    // Eight bit-times were measured: divide by 8, rounding to nearest.
    // One extra bit keeps N+4 from wrapping.
    function automatic logic [c_CNT_W:0] f_round_baud(input logic [c_CNT_W-1:0] n);
        return ({1'b0, n} + {{c_CNT_W{1'b0}}, 1'b0} + (c_CNT_W+1)'(4)) >> 3;
    endfunction

endpackage : rxuart_pkg
`default_nettype wire

// File: rtl/rxuart_edge_timer.sv
`default_nettype none
//----------------------------------------------------------------------------
//  Module     : rxuart_edge_timer
//  Description: Falling-edge detector plus the cycle and edge counters used
//               to time the sync character.
//  Revision   : 1.0 - initial release
//
//  Ports:
//    i_clk     clock
//    i_reset   asynchronous active-high reset
//    i_rx      synchronized rx line
//    i_clear   zero both counters (has priority over i_enable)
//    i_enable  count cycles (saturating at TIMEOUT) and falling edges
//    o_fall    falling edge on i_rx this cycle
//    o_edges   falling edges counted while enabled
//    o_cnt     cycles counted while enabled
//    o_sat     o_cnt has reached TIMEOUT
//----------------------------------------------------------------------------
module rxuart_edge_timer
    import rxuart_pkg::*;
#(
    parameter logic [c_CNT_W-1:0] TIMEOUT = 28'hFFF_FFFF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx,
    input  logic               i_clear,
    input  logic               i_enable,
    output logic               o_fall,
    output logic [2:0]         o_edges,
    output logic [c_CNT_W-1:0] o_cnt,
    output logic               o_sat
);

    logic               r_prev_rx;
    logic [2:0]         r_edges;
    logic [c_CNT_W-1:0] r_cnt;

    assign o_fall  = r_prev_rx & ~i_rx;
    assign o_sat   = (r_cnt == TIMEOUT);
    assign o_edges = r_edges;
    assign o_cnt   = r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_prev_rx <= 1'b1;
            r_edges   <= 3'd0;
            r_cnt     <= '0;
        end else begin
            r_prev_rx <= i_rx;
            if (i_clear) begin
                r_edges <= 3'd0;
                r_cnt   <= '0;
            end else if (i_enable) begin
                if (!o_sat)
                    r_cnt <= r_cnt + 1'b1;
                if (o_fall)
                    r_edges <= r_edges + 3'd1;
            end
        end
    end

endmodule : rxuart_edge_timer
`default_nettype wire

// File: rtl/rxuart_autobaud.sv
`default_nettype none
//----------------------------------------------------------------------------
//  Module     : rxuart_autobaud
//  Description: Automatic baud-rate controller for rxuart. When armed it
//               waits for an idle-high guard period, times eight bit
//               periods of a 0x55 sync character, derives the rounded
//               clocks-per-baud value, loads the new setup word and pulses
//               the receiver reset so rxuart restarts with it.
//  Revision   : 1.0 - initial release
//
//  Build option:
//    RXUART_AUTOBAUD_VERIFY_EN - adds a VERIFY state after APPLY that
//    waits for the receiver to deliver SYNC_CHAR under the new setup,
//    restoring the pre-arm setup on a wrong character.
//
//  Ports:
//    i_clk       clock
//    i_reset     asynchronous active-high reset
//    i_ck_uart   synchronized rx line
//    i_arm       pulse: start auto-baud (ignored while busy)
//    i_abort     pulse: cancel the current operation
//    i_format    setup bits [29:24]
//    i_rx_wr     receiver character strobe (verify build only)
//    i_rx_data   receiver character (verify build only)
//    o_setup     setup word to rxuart
//    o_rx_reset  reset request to rxuart
//    o_busy      any state other than IDLE
//    o_done      pulse: new setup applied
//    o_fail      pulse: timeout, range error, abort or verify mismatch
//----------------------------------------------------------------------------
module rxuart_autobaud
    import rxuart_pkg::*;
#(
    parameter logic [30:0]        INITIAL_SETUP = 31'd868,
    parameter logic [c_CNT_W-1:0] TIMEOUT       = 28'hFFF_FFFF,
    parameter logic [23:0]        MIN_BAUD      = 24'd4,
    parameter logic [15:0]        GUARD         = 16'd32,
    parameter logic [7:0]         SYNC_CHAR     = c_SYNC_CHAR_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ck_uart,
    input  logic        i_arm,
    input  logic        i_abort,
    input  logic [5:0]  i_format,
    input  logic        i_rx_wr,
    input  logic [7:0]  i_rx_data,
    output logic [30:0] o_setup,
    output logic        o_rx_reset,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_fail
);

`ifdef RXUART_AUTOBAUD_VERIFY_EN
    localparam state_t c_ST_AFTER_APPLY = c_ST_VERIFY;
`else
    localparam state_t c_ST_AFTER_APPLY = c_ST_DONE;
`endif

    state_t             r_state;
    state_t             w_next;
    logic [15:0]        r_guard_cnt;
    logic               r_apply_cnt;
    logic               r_abort_pend;
    logic [30:0]        r_setup;

    logic               w_fall;
    logic               w_sat;
    logic [2:0]         w_edges;
    logic [c_CNT_W-1:0] w_cnt;
    logic               w_clear;
    logic               w_enable;
    logic [c_CNT_W:0]   w_baud;
    logic               w_range_ok;
    logic               w_arm_ok;

    assign w_clear  = (r_state == c_ST_WAIT_START) && w_fall;
    assign w_enable = (r_state == c_ST_MEASURE);
    assign w_arm_ok = (r_state == c_ST_IDLE) && i_arm && !i_abort;

    rxuart_edge_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_edge_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_rx     (i_ck_uart),
        .i_clear  (w_clear),
        .i_enable (w_enable),
        .o_fall   (w_fall),
        .o_edges  (w_edges),
        .o_cnt    (w_cnt),
        .o_sat    (w_sat)
    );

    // The counter stops once MEASURE is left, and its final increment made
    // it equal N = cnt + 1, so in CALC it already holds the 8-bit-time count.
    assign w_baud     = f_round_baud(w_cnt);
    assign w_range_ok = (w_baud >= {5'd0, MIN_BAUD}) &&
                        (w_baud <= (c_CNT_W+1)'(24'hFF_FFFF));

`ifdef RXUART_AUTOBAUD_VERIFY_EN
    logic [30:0]        r_saved_setup;
    logic [c_CNT_W-1:0] r_vcnt;
    logic               w_v_timeout;
    logic               w_v_match;

    // Allow 16 bit-times at the new rate for the receiver to deliver a char
    assign w_v_timeout = (r_vcnt >= {r_setup[c_BAUD_MSB:c_BAUD_LSB], 4'b0000});
    assign w_v_match   = (i_rx_data == SYNC_CHAR);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_saved_setup <= INITIAL_SETUP;
            r_vcnt        <= '0;
        end else begin
            if (w_arm_ok)
                r_saved_setup <= r_setup;
            if (r_state == c_ST_VERIFY)
                r_vcnt <= r_vcnt + 1'b1;
            else
                r_vcnt <= '0;
        end
    end
`else
    logic w_unused_rx;
    assign w_unused_rx = ^{i_rx_wr, i_rx_data, SYNC_CHAR};
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_arm_ok)
                    w_next = c_ST_GUARD_WAIT;
            end
            c_ST_GUARD_WAIT: begin
                if (i_abort)
                    w_next = c_ST_FAIL;
                else if (i_ck_uart && (r_guard_cnt == GUARD - 16'd1))
                    w_next = c_ST_WAIT_START;
            end
            c_ST_WAIT_START: begin
                if (i_abort)
                    w_next = c_ST_FAIL;
                else if (w_fall)
                    w_next = c_ST_MEASURE;
            end
            c_ST_MEASURE: begin
                // Timeout wins so a saturated count is never used for N
                if (i_abort || w_sat)
                    w_next = c_ST_FAIL;
                else if (w_fall && (w_edges == 3'd3))
                    w_next = c_ST_CALC;
            end
            c_ST_CALC: begin
                if (i_abort || !w_range_ok)
                    w_next = c_ST_FAIL;
                else
                    w_next = c_ST_APPLY;
            end
            c_ST_APPLY: begin
                // The receiver reset always runs its full two cycles
                if (r_apply_cnt) begin
                    if (i_abort || r_abort_pend)
                        w_next = c_ST_FAIL;
                    else
                        w_next = c_ST_AFTER_APPLY;
                end
            end
`ifdef RXUART_AUTOBAUD_VERIFY_EN
            c_ST_VERIFY: begin
                if (i_abort)
                    w_next = c_ST_FAIL;
                else if (i_rx_wr)
                    w_next = w_v_match ? c_ST_DONE : c_ST_FAIL;
                else if (w_v_timeout)
                    w_next = c_ST_FAIL;
            end
`endif
            c_ST_DONE: w_next = c_ST_IDLE;
            c_ST_FAIL: w_next = c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_busy     = (r_state != c_ST_IDLE);
        o_rx_reset = (r_state == c_ST_APPLY);
        o_done     = (r_state == c_ST_DONE);
        o_fail     = (r_state == c_ST_FAIL);
    end

    assign o_setup = r_setup;

    // Datapath registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_guard_cnt  <= 16'd0;
            r_apply_cnt  <= 1'b0;
            r_abort_pend <= 1'b0;
            r_setup      <= INITIAL_SETUP;
        end else begin
            // Guard counts consecutive high cycles only
            if ((r_state == c_ST_GUARD_WAIT) && i_ck_uart)
                r_guard_cnt <= r_guard_cnt + 16'd1;
            else
                r_guard_cnt <= 16'd0;

            if (r_state == c_ST_APPLY) begin
                r_apply_cnt <= ~r_apply_cnt;
                if (i_abort)
                    r_abort_pend <= 1'b1;
            end else begin
                r_apply_cnt  <= 1'b0;
                r_abort_pend <= 1'b0;
            end

            if ((r_state == c_ST_CALC) && (w_next == c_ST_APPLY)) begin
                r_setup[30]                        <= 1'b0;
                r_setup[c_FORMAT_MSB:c_FORMAT_LSB] <= i_format;
                r_setup[c_BAUD_MSB:c_BAUD_LSB]     <= w_baud[c_BAUD_MSB:c_BAUD_LSB];
            end
`ifdef RXUART_AUTOBAUD_VERIFY_EN
            // A wrong character means the new rate is wrong: put the old one back
            if ((r_state == c_ST_VERIFY) && !i_abort && i_rx_wr && !w_v_match)
                r_setup <= r_saved_setup;
`endif
        end
    end

endmodule : rxuart_autobaud
`default_nettype wire

// File: tb/tb_rxuart_autobaud.sv
`timescale 1ns/1ps
`default_nettype none
//----------------------------------------------------------------------------
//  Module     : tb_rxuart_autobaud
//  Description: Directed self-checking bench for rxuart_autobaud. Sync
//               characters are driven as bit-boundary offset tables; a
//               negedge monitor records pulse counts and cycle stamps.
//               Verify-phase cases run when RXUART_AUTOBAUD_VERIFY_EN is set.
//  Revision   : 1.0 - initial release
//----------------------------------------------------------------------------
module tb_rxuart_autobaud;

    localparam logic [27:0] c_TIMEOUT = 28'd12000;

    logic        r_clk = 1'b0;
    logic        r_rst = 1'b1;
    logic        r_ck = 1'b1;
    logic        r_arm = 1'b0;
    logic        r_abort = 1'b0;
    logic [5:0]  r_format = 6'd0;
    logic        r_rx_wr = 1'b0;
    logic [7:0]  r_rx_data = 8'd0;
    logic [30:0] w_setup;
    logic        w_rx_reset;
    logic        w_busy;
    logic        w_done;
    logic        w_fail;

    int n_checks = 0;
    int n_fail = 0;

    rxuart_autobaud #(
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .i_clk      (r_clk),
        .i_reset    (r_rst),
        .i_ck_uart  (r_ck),
        .i_arm      (r_arm),
        .i_abort    (r_abort),
        .i_format   (r_format),
        .i_rx_wr    (r_rx_wr),
        .i_rx_data  (r_rx_data),
        .o_setup    (w_setup),
        .o_rx_reset (w_rx_reset),
        .o_busy     (w_busy),
        .o_done     (w_done),
        .o_fail     (w_fail)
    );

    always #5 r_clk = ~r_clk;

    // Cycle stamp and output monitor
    int   cyc = 0;
    int   rr_total = 0, done_total = 0, fail_total = 0;
    int   rr_start = -1, done_cyc = -1, fail_cyc = -1;
    logic r_prev_rr = 1'b0;

    always @(posedge r_clk) cyc <= cyc + 1;

    always @(negedge r_clk) begin
        r_prev_rr <= w_rx_reset;
        if (w_rx_reset) rr_total <= rr_total + 1;
        if (w_rx_reset && !r_prev_rr) rr_start <= cyc;
        if (w_done) begin done_total <= done_total + 1; done_cyc <= cyc; end
        if (w_fail) begin fail_total <= fail_total + 1; fail_cyc <= cyc; end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge r_clk);
        #1;
    endtask

    int offs [11];

    task automatic build_offs(input int num, input int den);
        for (int j = 0; j < 11; j++) offs[j] = (j * num) / den;
    endtask

    // Drives start, 0x55 LSB first, stop; returns the cycle stamp at which
    // the 4th measured fall (start of data bit 7) was driven.
    task automatic send_sync(input int off [11], output int f4);
        logic [9:0] frame;
        frame = {1'b1, 8'h55, 1'b0};
        f4 = 0;
        for (int j = 0; j < 10; j++) begin
            r_ck = frame[j];
            if (j == 8) f4 = cyc;
            repeat (off[j+1] - off[j]) @(negedge r_clk);
        end
    endtask

    task automatic pulse_arm();
        r_arm = 1'b1;
        @(negedge r_clk);
        r_arm = 1'b0;
    endtask

    task automatic run_sync(input logic [5:0] fmt, output int f4);
        r_format = fmt;
        pulse_arm();
        repeat (50) @(negedge r_clk);
        send_sync(offs, f4);
    endtask

    task automatic confirm(input logic [7:0] d);
`ifdef RXUART_AUTOBAUD_VERIFY_EN
        repeat (3) @(negedge r_clk);
        r_rx_data = d;
        r_rx_wr = 1'b1;
        @(negedge r_clk);
        r_rx_wr = 1'b0;
`else
        r_rx_data = d;
`endif
    endtask

    initial begin
        int f4, k0, rr0, dn0, fl0;

        // Reset state
        settle(3);
        check("rst_setup", 32'(w_setup), 32'd868);
        check("rst_busy", 32'(w_busy), 0);
        check("rst_rx_reset", 32'(w_rx_reset), 0);
        check("rst_done_fail", 32'({w_done, w_fail}), 0);
        @(negedge r_clk);
        r_rst = 1'b0;
        settle(2);

        // A: 868 clk/bit, format 3
        rr0 = rr_total; dn0 = done_total; fl0 = fail_total;
        build_offs(868, 1);
        run_sync(6'h03, f4);
        confirm(8'h55);
        settle(5);
        check("A_setup", 32'(w_setup), 32'h0300_0364);
        check("A_rr_len", rr_total - rr0, 2);
        check("A_rr_start", rr_start - f4, 2);
        check("A_done_cnt", done_total - dn0, 1);
        check("A_no_fail", fail_total - fl0, 0);
`ifndef RXUART_AUTOBAUD_VERIFY_EN
        check("A_done_lat", done_cyc - f4, 4);
`endif

        // B: 217 clk/bit with +-3 cycle edge jitter
        dn0 = done_total;
        build_offs(217, 1);
        offs[1] += 2; offs[2] -= 3; offs[3] += 1; offs[4] += 3;
        offs[5] -= 2; offs[6] -= 1; offs[7] += 3; offs[8] -= 3;
        run_sync(6'h15, f4);
        confirm(8'h55);
        settle(5);
        check("B_setup", 32'(w_setup), 32'({1'b0, 6'h15, 24'd217}));
        check("B_done_cnt", done_total - dn0, 1);

        // C: 869.5 clk/bit average, N = 6956 rounds to 870
        dn0 = done_total;
        build_offs(6956, 8);
        run_sync(6'h00, f4);
        confirm(8'h55);
        settle(5);
        check("C_setup", 32'(w_setup), 32'd870);
        check("C_done_cnt", done_total - dn0, 1);

        // D: single fall then line held low -> timeout
        rr0 = rr_total; fl0 = fail_total;
        pulse_arm();
        repeat (50) @(negedge r_clk);
        r_ck = 1'b0;
        k0 = cyc;
        repeat (int'(c_TIMEOUT) + 10) @(negedge r_clk);
        r_ck = 1'b1;
        settle(2);
        check("D_fail_cnt", fail_total - fl0, 1);
        check("D_fail_cyc", fail_cyc - k0, int'(c_TIMEOUT) + 2);
        check("D_setup", 32'(w_setup), 32'd870);
        check("D_no_rr", rr_total - rr0, 0);

        // E: 2 clk/bit -> below MIN_BAUD
        rr0 = rr_total; fl0 = fail_total;
        build_offs(2, 1);
        run_sync(6'h01, f4);
        settle(5);
        check("E_fail_cnt", fail_total - fl0, 1);
        check("E_fail_cyc", fail_cyc - f4, 2);
        check("E_no_rr", rr_total - rr0, 0);
        check("E_setup", 32'(w_setup), 32'd870);

        // F: asynchronous reset mid-MEASURE, then a normal run
        pulse_arm();
        repeat (50) @(negedge r_clk);
        r_ck = 1'b0;
        repeat (100) @(negedge r_clk);
        #1;
        check("F_busy_meas", 32'(w_busy), 1);
        r_rst = 1'b1;
        #1;
        check("F_rst_setup", 32'(w_setup), 32'd868);
        check("F_rst_busy", 32'(w_busy), 0);
        @(negedge r_clk);
        r_rst = 1'b0;
        r_ck = 1'b1;
        settle(2);
        dn0 = done_total;
        build_offs(100, 1);
        run_sync(6'h2A, f4);
        confirm(8'h55);
        settle(5);
        check("F_setup", 32'(w_setup), 32'({1'b0, 6'h2A, 24'd100}));
        check("F_done_cnt", done_total - dn0, 1);

        // G: abort in GUARD_WAIT
        fl0 = fail_total;
        pulse_arm();
        repeat (5) @(negedge r_clk);
        r_abort = 1'b1;
        k0 = cyc;
        @(negedge r_clk);
        r_abort = 1'b0;
        settle(3);
        check("G_fail_cnt", fail_total - fl0, 1);
        check("G_fail_cyc", fail_cyc - k0, 1);
        check("G_idle", 32'(w_busy), 0);

        // H: arm and abort together in IDLE -> no effect
        fl0 = fail_total;
        r_arm = 1'b1; r_abort = 1'b1;
        @(negedge r_clk);
        r_arm = 1'b0; r_abort = 1'b0;
        settle(3);
        check("H_busy", 32'(w_busy), 0);
        check("H_no_fail", fail_total - fl0, 0);

`ifdef RXUART_AUTOBAUD_VERIFY_EN
        // V1: wrong verify character restores the pre-arm setup
        fl0 = fail_total;
        build_offs(100, 1);
        run_sync(6'h07, f4);
        confirm(8'h41);
        settle(5);
        check("V1_fail_cnt", fail_total - fl0, 1);
        check("V1_setup", 32'(w_setup), 32'({1'b0, 6'h2A, 24'd100}));

        // V2: correct verify character completes
        dn0 = done_total;
        run_sync(6'h07, f4);
        confirm(8'h55);
        settle(5);
        check("V2_done_cnt", done_total - dn0, 1);
        check("V2_setup", 32'(w_setup), 32'({1'b0, 6'h07, 24'd100}));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rxuart_autobaud
`default_nettype wire
